wb_mtimer: RTL

WB_MTIMER -- requirements
Module: wb_mtimer

---
 rtl/wb_mtimer_pkg.sv | 34 +++
 rtl/wb_mtimer_if.sv | 24 ++
 rtl/wb_mtimer_counter.sv | 49 ++++
 rtl/wb_mtimer.sv | 102 ++++++++++
 4 files changed

// File: rtl/wb_mtimer_pkg.sv
// wb_mtimer shared definitions: register map, index enum, byte-merge helper.
// Used by wb_mtimer and mtimer_counter.
package wb_mtimer_pkg;

    // Byte offsets inside the 16-byte window
    localparam logic [3:0] MTIME_LO_OFS    = 4'h0;
    localparam logic [3:0] MTIME_HI_OFS    = 4'h4;
    localparam logic [3:0] MTIMECMP_LO_OFS = 4'h8;
    localparam logic [3:0] MTIMECMP_HI_OFS = 4'hC;

    // Prescale counter width; covers PRESCALE up to 2^16
    localparam int unsigned PCNT_W = 16;

    typedef enum logic [1:0] {
        REG_MTIME_LO    = 2'd0,
        REG_MTIME_HI    = 2'd1,
        REG_MTIMECMP_LO = 2'd2,
        REG_MTIMECMP_HI = 2'd3
    } reg_idx_e;

    // Replace the bytes of old_v selected by be with those of new_v
    function automatic logic [31:0] be_merge(
        input logic [31:0] old_v,
        input logic [31:0] new_v,
        input logic [3:0]  be
    );
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/wb_mtimer_if.sv
// Pipelined Wishbone B4 bus bundle, 32-bit data, byte addressing.
// master drives the request, slave drives ack/stall/err/dat_s.
interface wb_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat_m;
    logic        ack;
    logic        stall;
    logic        err;
    logic [31:0] dat_s;

    modport master (
        output cyc, stb, we, adr, sel, dat_m,
        input  ack, stall, err, dat_s
    );

    modport slave (
        input  cyc, stb, we, adr, sel, dat_m,
        output ack, stall, err, dat_s
    );
endinterface

// File: rtl/wb_mtimer_counter.sv
// mtimer_counter: prescaler plus free-running 64-bit mtime.
// Bus writes to either word win over the increment in the same cycle.
module mtimer_counter
    import wb_mtimer_pkg::*;
#(
    parameter int unsigned PRESCALE = 32'd50
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        lo_we_i,
    input  logic        hi_we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic [63:0] mtime_o
);

    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PRESCALE - 1);

    logic [PCNT_W-1:0] pcnt_q, pcnt_d;
    logic [63:0]       mtime_q, mtime_d;
    logic              tick;

    assign tick = (pcnt_q == PCNT_LAST);

    // Next-state: prescaler wrap, increment, or byte-wise load of one word
    always_comb begin
        pcnt_d  = tick ? '0 : pcnt_q + PCNT_W'(1);
        mtime_d = mtime_q + 64'(tick);
        if (lo_we_i) begin
            mtime_d = {mtime_q[63:32], be_merge(mtime_q[31:0], wdata_i, be_i)};
        end else if (hi_we_i) begin
            mtime_d = {be_merge(mtime_q[63:32], wdata_i, be_i), mtime_q[31:0]};
        end
    end

    // State registers; the prescaler is never disturbed by bus writes
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pcnt_q  <= '0;
            mtime_q <= '0;
        end else begin
            pcnt_q  <= pcnt_d;
            mtime_q <= mtime_d;
        end
    end

    assign mtime_o = mtime_q;

endmodule

// File: rtl/wb_mtimer.sv
// wb_mtimer: RISC-V machine timer (mtime/mtimecmp) on a Wishbone slave.
// Optional macro WB_MTIMER_SNAPSHOT_EN makes LO-then-HI mtime reads atomic.
module wb_mtimer
    import wb_mtimer_pkg::*;
#(
    parameter int unsigned PRESCALE = 32'd50
) (
    input  logic clk,
    input  logic rst,
    wb_if.slave  wb,
    output logic irq_timer
);

    logic        accept;
    logic        wr;
    reg_idx_e    idx;
    logic [63:0] mtime;
    logic [31:0] rdata;
    logic [63:0] cmp_q, cmp_d;
    logic        ack_q;
    logic [31:0] dat_q;
    logic        irq_q;
    logic        unused_adr;

    assign accept     = wb.cyc & wb.stb & ~rst;
    assign wr         = accept & wb.we & (|wb.sel);
    assign idx        = reg_idx_e'(wb.adr[3:2]);
    assign unused_adr = ^{wb.adr[31:4], wb.adr[1:0]};

    mtimer_counter #(
        .PRESCALE (PRESCALE)
    ) u_counter (
        .clk_i   (clk),
        .rst_i   (rst),
        .lo_we_i (wr && idx == REG_MTIME_LO),
        .hi_we_i (wr && idx == REG_MTIME_HI),
        .be_i    (wb.sel),
        .wdata_i (wb.dat_m),
        .mtime_o (mtime)
    );

`ifdef WB_MTIMER_SNAPSHOT_EN
    logic [31:0] shadow_q;

    // Capture the upper word whenever the lower word is read
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q <= '0;
        end else if (accept && !wb.we && idx == REG_MTIME_LO) begin
            shadow_q <= mtime[63:32];
        end
    end
`endif

    // Read mux, sampled in the accept cycle
    always_comb begin
        rdata = '0;
        unique case (idx)
            REG_MTIME_LO:    rdata = mtime[31:0];
`ifdef WB_MTIMER_SNAPSHOT_EN
            REG_MTIME_HI:    rdata = shadow_q;
`else
            REG_MTIME_HI:    rdata = mtime[63:32];
`endif
            REG_MTIMECMP_LO: rdata = cmp_q[31:0];
            REG_MTIMECMP_HI: rdata = cmp_q[63:32];
        endcase
    end

    // Byte-wise mtimecmp update
    always_comb begin
        cmp_d = cmp_q;
        if (wr && idx == REG_MTIMECMP_LO) begin
            cmp_d[31:0] = be_merge(cmp_q[31:0], wb.dat_m, wb.sel);
        end else if (wr && idx == REG_MTIMECMP_HI) begin
            cmp_d[63:32] = be_merge(cmp_q[63:32], wb.dat_m, wb.sel);
        end
    end

    // Bus response, compare register and interrupt
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_q <= 1'b0;
            dat_q <= '0;
            cmp_q <= '1;
            irq_q <= 1'b0;
        end else begin
            ack_q <= accept;
            dat_q <= accept ? rdata : '0;
            cmp_q <= cmp_d;
            irq_q <= (mtime >= cmp_q);
        end
    end

    // A pending ack is dropped while reset is held
    assign wb.ack   = ack_q & ~rst;
    assign wb.dat_s = rst ? '0 : dat_q;
    assign wb.stall = 1'b0;
    assign wb.err   = 1'b0;
    assign irq_timer = irq_q;

endmodule
